clk_switch_ctrl: RTL and testbench

Sequencing controller that drives the `sel` input of the clock mux cell. It accepts source-change requests, gates the downstream clock, and waits a drain interval before moving `sel`. It then waits a settle interval before re-enabling the clock and acknowledging. All logic runs on one always-on reference clock, so the mux select never changes while the gated clock is live.

---
 rtl/clk_switch_ctrl_if.sv | 25 ++
 rtl/clk_switch_ctrl.sv | 124 ++++++++++++
 tb/tb_clk_switch_ctrl.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/clk_switch_ctrl_if.sv
// rtl/clk_switch_ctrl_if.sv - request/status bundle between requester and clock switch controller
// The controller side takes the slave modport; the requester drives through master.
interface clk_switch_ctrl_if #(
   parameter int CLK_NUM = 3,
   parameter int SEL_W   = $clog2(CLK_NUM)
);
   logic               req;
   logic [SEL_W-1:0]   req_sel;
   logic [CLK_NUM-1:0] clk_valid;
   logic [SEL_W-1:0]   sel;
   logic               clk_en;
   logic               busy;
   logic               ack;
   logic               err;

   modport master (
      output req, req_sel, clk_valid,
      input  sel, clk_en, busy, ack, err
   );

   modport slave (
      input  req, req_sel, clk_valid,
      output sel, clk_en, busy, ack, err
   );
endinterface

// File: rtl/clk_switch_ctrl.sv
// rtl/clk_switch_ctrl.sv - glitch-free clock mux select sequencer (gate, drain, switch, settle, ungate)
// All outputs come straight from registers so the mux cell never sees an input-driven glitch.
module clk_switch_ctrl #(
   parameter int CLK_NUM    = 3,
   parameter int SEL_W      = $clog2(CLK_NUM),
   parameter int RST_SEL    = 0,
   parameter int GATE_CYC   = 4,
   parameter int SETTLE_CYC = 8
) (
   input  logic              clk,
   input  logic              rst,
   clk_switch_ctrl_if.slave  bus
);
   localparam int CNT_MAX  = ((GATE_CYC > SETTLE_CYC) ? GATE_CYC : SETTLE_CYC) - 1;
   localparam int CNT_W    = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
   localparam int SEL_SPAN = 1 << SEL_W;

   localparam logic [CNT_W-1:0] GATE_LOAD   = CNT_W'(GATE_CYC - 1);
   localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);
   localparam logic [SEL_W-1:0] RESET_SEL   = SEL_W'(RST_SEL);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_DRAIN  = 2'd1;
   localparam logic [1:0] ST_SETTLE = 2'd2;

   logic [1:0]       state;
   logic [SEL_W-1:0] tgt;
   logic [SEL_W-1:0] prev;
   logic [CNT_W-1:0] cnt;
   logic             abort;
   logic [SEL_W-1:0] sel_reg;
   logic             en_reg;
   logic             ack_reg;
   logic             err_reg;

   // Select codes beyond CLK_NUM read as never-valid sources.
   logic [SEL_SPAN-1:0] valid_pad;
   for (genvar i = 0; i < SEL_SPAN; i++) begin : g_pad
      if (i < CLK_NUM) begin : g_src
         assign valid_pad[i] = bus.clk_valid[i];
      end else begin : g_none
         assign valid_pad[i] = 1'b0;
      end
   end

   logic req_ok;
   logic tgt_ok;
   assign req_ok = valid_pad[bus.req_sel];
   assign tgt_ok = valid_pad[tgt];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= ST_IDLE;
         tgt     <= RESET_SEL;
         prev    <= RESET_SEL;
         cnt     <= '0;
         abort   <= 1'b0;
         sel_reg <= RESET_SEL;
         en_reg  <= 1'b1;
         ack_reg <= 1'b0;
         err_reg <= 1'b0;
      end else begin
         ack_reg <= 1'b0;
         err_reg <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (bus.req) begin
                  if (!req_ok) begin
                     err_reg <= 1'b1;
                  end else if (bus.req_sel == sel_reg) begin
                     ack_reg <= 1'b1;
                  end else begin
                     tgt    <= bus.req_sel;
                     prev   <= sel_reg;
                     en_reg <= 1'b0;
                     cnt    <= GATE_LOAD;
                     state  <= ST_DRAIN;
                  end
               end
            end
            ST_DRAIN: begin
               if (!tgt_ok) begin
                  en_reg  <= 1'b1;
                  err_reg <= 1'b1;
                  state   <= ST_IDLE;
               end else if (cnt == '0) begin
                  sel_reg <= tgt;
                  cnt     <= SETTLE_LOAD;
                  state   <= ST_SETTLE;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            ST_SETTLE: begin
               // Fall back to the old source once; a full settle runs again on it.
               if (!tgt_ok && !abort) begin
                  sel_reg <= prev;
                  abort   <= 1'b1;
                  cnt     <= SETTLE_LOAD;
               end else if (cnt == '0) begin
                  en_reg  <= 1'b1;
                  ack_reg <= ~abort;
                  err_reg <= abort;
                  abort   <= 1'b0;
                  state   <= ST_IDLE;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            default: begin
               en_reg <= 1'b1;
               abort  <= 1'b0;
               state  <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.sel    = sel_reg;
   assign bus.clk_en = en_reg;
   assign bus.busy   = (state != ST_IDLE);
   assign bus.ack    = ack_reg;
   assign bus.err    = err_reg;
endmodule

// File: tb/tb_clk_switch_ctrl.sv
// tb/tb_clk_switch_ctrl.sv - scoreboard bench for clk_switch_ctrl with a transaction-level reference model
module tb_clk_switch_ctrl;
   localparam int G = 4;
   localparam int S = 8;

   typedef struct {
      bit         is_err;
      int         t;
      logic [1:0] sel;
   } pulse_t;

   typedef struct {
      int         t;
      logic [1:0] v;
   } sel_ev_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   errors = 0;
   int   checks = 0;

   pulse_t  pq[$];
   sel_ev_t sq[$];
   pulse_t  mp;
   sel_ev_t ms;
   logic [1:0] last_sel = 2'd0;
   logic [1:0] model_sel = 2'd0;

   clk_switch_ctrl_if #(.CLK_NUM(3), .SEL_W(2)) bus ();

   clk_switch_ctrl #(
      .CLK_NUM(3), .SEL_W(2), .RST_SEL(0), .GATE_CYC(G), .SETTLE_CYC(S)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d want %0d (cyc %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (rst) begin
         last_sel = bus.sel;
      end else begin
         if (bus.ack || bus.err) begin
            check("ack_err_exclusive", int'(bus.ack & bus.err), 0);
            if (pq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_pulse: got ack=%0b err=%0b want none (cyc %0d)", bus.ack, bus.err, cyc);
            end else begin
               mp = pq.pop_front();
               check("pulse_is_err", int'(bus.err), int'(mp.is_err));
               check("pulse_time", cyc, mp.t);
               check("pulse_sel", int'(bus.sel), int'(mp.sel));
               check("pulse_clk_en", int'(bus.clk_en), 1);
               check("pulse_busy", int'(bus.busy), 0);
            end
         end
         if (bus.sel !== last_sel) begin
            check("sel_change_gated", int'(bus.clk_en), 0);
            if (sq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_sel_change: got %0d want %0d (cyc %0d)", bus.sel, last_sel, cyc);
            end else begin
               ms = sq.pop_front();
               check("sel_value", int'(bus.sel), int'(ms.v));
               check("sel_time", cyc, ms.t);
            end
         end
         last_sel = bus.sel;
      end
   end

   // Output cycle k after the sampling edge is seen at the negedge where cyc == c0 + k.
   task automatic do_txn(input logic [1:0] rs, input logic [2:0] v, input int d, input bit rst_mid);
      int  c0;
      int  kend;
      int  gap;
      bit  full;
      c0   = cyc;
      full = 1'b0;
      bus.clk_valid = v;
      bus.req       = 1'b1;
      bus.req_sel   = rs;
      if (rs >= 2'd3 || !v[rs]) begin
         pq.push_back('{1'b1, c0 + 1, model_sel});
         kend = 1;
      end else if (rs == model_sel) begin
         pq.push_back('{1'b0, c0 + 1, model_sel});
         kend = 1;
      end else begin
         full = 1'b1;
         if (d >= 1 && d <= G) begin
            pq.push_back('{1'b1, c0 + d + 1, model_sel});
            kend = d + 1;
         end else begin
            sq.push_back('{c0 + G + 1, rs});
            if (d > G && d <= G + S) begin
               sq.push_back('{c0 + d + 1, model_sel});
               pq.push_back('{1'b1, c0 + d + 1 + S, model_sel});
               kend = d + 1 + S;
            end else begin
               pq.push_back('{1'b0, c0 + G + S + 1, rs});
               model_sel = rs;
               kend = G + S + 1;
            end
         end
      end
      if (rst_mid) kend = 25;
      gap = int'($urandom_range(0, 2));
      for (int k = 1; k <= kend + gap; k++) begin
         @(posedge clk);
         #1;
         if (k == 1) bus.req = 1'b0;
         if (full && d == k) bus.clk_valid[rs] = 1'b0;
         if (full && kend > 6 && k == 6) begin
            bus.req     = 1'b1;
            bus.req_sel = 2'($urandom_range(0, 3));
         end
         if (k == 7) bus.req = 1'b0;
         if (rst_mid && k == 7) begin
            rst = 1'b1;
            pq.delete();
            sq.delete();
            model_sel = 2'd0;
            #1;
            check("midrst_sel", int'(bus.sel), 0);
            check("midrst_clk_en", int'(bus.clk_en), 1);
            check("midrst_busy", int'(bus.busy), 0);
            check("midrst_pulses", int'(bus.ack | bus.err), 0);
         end
         if (rst_mid && k == 8) rst = 1'b0;
      end
      bus.clk_valid = 3'b111;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish (cyc %0d)", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0] rs;
      logic [2:0] v;
      int         d;
      bus.req       = 1'b0;
      bus.req_sel   = 2'd0;
      bus.clk_valid = 3'b111;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      check("reset_sel", int'(bus.sel), 0);
      check("reset_clk_en", int'(bus.clk_en), 1);
      check("reset_busy", int'(bus.busy), 0);
      check("reset_ack", int'(bus.ack), 0);
      check("reset_err", int'(bus.err), 0);
      @(posedge clk);
      #1;

      do_txn(2'd2, 3'b111, 0, 1'b0);
      do_txn(2'd3, 3'b111, 0, 1'b0);
      do_txn(2'd1, 3'b101, 0, 1'b0);
      do_txn(2'd2, 3'b111, 0, 1'b0);
      do_txn(2'd0, 3'b111, 0, 1'b0);
      do_txn(2'd2, 3'b111, 3, 1'b0);
      do_txn(2'd2, 3'b111, 7, 1'b0);
      do_txn(2'd2, 3'b111, 12, 1'b0);
      do_txn(2'd1, 3'b111, 0, 1'b0);
      do_txn(2'd2, 3'b111, 0, 1'b1);

      for (int n = 0; n < 40; n++) begin
         rs = 2'($urandom_range(0, 3));
         v  = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) : 3'b111;
         d  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 13)) : 0;
         do_txn(rs, v, d, 1'b0);
      end

      repeat (3) @(posedge clk);
      #1;
      check("pulse_queue_drained", pq.size(), 0);
      check("sel_queue_drained", sq.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
